// File: rtl/audio_pkg.sv
// Shared audio constants for the FIR output path and the I2S transmitter.
// Contents:
//   AUDIO_W / AUDIO_DW / AUDIO_SLOT / AUDIO_BCLK_DIV : default sample width, bits sent per slot,
//                                                      BCLKs per slot, sys clocks per BCLK half
//   FRAME_BITS                                       : BCLK periods per stereo frame
//   SAT_MAX / SAT_MIN                                : signed limits of an AUDIO_DW-bit word
package audio_pkg;

  localparam int unsigned AUDIO_W        = 32;
  localparam int unsigned AUDIO_DW       = 24;
  localparam int unsigned AUDIO_SLOT     = 32;
  localparam int unsigned AUDIO_BCLK_DIV = 4;

  localparam int unsigned FRAME_BITS = 2 * AUDIO_SLOT;

  localparam int SAT_MAX = (2 ** (AUDIO_DW - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (AUDIO_DW - 1));

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S master timing: divides the system clock into BCLK, counts bit positions within a frame
// and derives LRCLK plus single-cycle strobes used by the data path.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   bclk          : bit clock (registered)
//   lrclk         : 0 = left slot, 1 = right slot (registered, changes with bclk falling)
//   fall          : high in the system cycle whose edge takes bclk 1->0
//   frame_start   : fall that begins a new frame (bit count wraps, or first fall after reset)
//   next_pos      : slot bit position that becomes current at this fall (bit count mod SLOT)
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int unsigned SLOT     = AUDIO_SLOT,
  parameter int unsigned BCLK_DIV = AUDIO_BCLK_DIV,
  localparam int unsigned PW      = $clog2(SLOT)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          bclk,
  output logic          lrclk,
  output logic          fall,
  output logic          frame_start,
  output logic [PW-1:0] next_pos
);

  localparam int unsigned FrameLen = 2 * SLOT;
  localparam int unsigned CW       = $clog2(FrameLen);
  localparam int unsigned DVW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DVW-1:0] div_q;
  logic           bclk_q;
  logic           lrclk_q;
  logic           first_q;
  logic [CW-1:0]  bit_q;
  logic [CW-1:0]  bit_nxt;
  logic           div_wrap;
  logic           last_bit;

  always_comb begin
    div_wrap    = (div_q == DVW'(BCLK_DIV - 1));
    last_bit    = (bit_q == CW'(FrameLen - 1));
    fall        = bclk_q & div_wrap;
    // After reset the bit count sits at 0 with nothing loaded, so the first fall also loads.
    frame_start = fall & (last_bit | first_q);
    bit_nxt     = last_bit ? '0 : bit_q + CW'(1);
    next_pos    = (bit_nxt >= CW'(SLOT)) ? PW'(bit_nxt - CW'(SLOT)) : PW'(bit_nxt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      first_q <= 1'b1;
      bit_q   <= '0;
    end else begin
      if (div_wrap) begin
        div_q  <= '0;
        bclk_q <= ~bclk_q;
      end else begin
        div_q <= div_q + DVW'(1);
      end
      if (fall) begin
        bit_q   <= bit_nxt;
        lrclk_q <= (bit_nxt >= CW'(SLOT));
        first_q <= 1'b0;
      end
    end
  end

  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Master-mode I2S transmitter for the filtered mono stream. One saturated sample per frame is
// taken through a single-entry holding register and sent MSB-first in both L and R slots.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   sample_in     : signed W-bit sample from the filter
//   sample_valid  : sample_in valid this cycle
//   sample_ready  : holding register empty; transfer happens when valid & ready
//   i2s_bclk      : bit clock to codec
//   i2s_lrclk     : 0 = left slot, 1 = right slot
//   i2s_sdata     : serial data, updated on bclk falling edges (one-bit I2S delay)
//   underrun      : one-cycle pulse when a frame starts with the holding register empty
module i2s_tx_serializer
  import audio_pkg::*;
#(
  parameter int unsigned W        = AUDIO_W,
  parameter int unsigned DW       = AUDIO_DW,
  parameter int unsigned SLOT     = AUDIO_SLOT,
  parameter int unsigned BCLK_DIV = AUDIO_BCLK_DIV
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] sample_in,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         i2s_bclk,
  output logic         i2s_lrclk,
  output logic         i2s_sdata,
  output logic         underrun
);

  localparam int unsigned PW = $clog2(SLOT);

  logic          fall;
  logic          frame_start;
  logic [PW-1:0] next_pos;

  i2s_clk_gen #(
    .SLOT     (SLOT),
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clock       (clock),
    .reset       (reset),
    .bclk        (i2s_bclk),
    .lrclk       (i2s_lrclk),
    .fall        (fall),
    .frame_start (frame_start),
    .next_pos    (next_pos)
  );

  logic [DW-1:0] hold_q;
  logic          hold_full_q;
  logic          hold_full_d;
  logic          ready_q;
  // Word of the current frame; also the repeat source when the holding register is empty.
  logic [DW-1:0] word_q;
  logic          sdata_q;
  logic          underrun_q;

  logic [W-DW:0] upper;
  logic [DW-1:0] sat_val;
  logic          accept;
  logic [DW-1:0] load_word;
  logic [DW-1:0] frame_word;
  logic          sdata_d;

  // Saturate: in range iff every bit from the DW-bit sign position upward agrees.
  always_comb begin
    upper = sample_in[W-1:DW-1];
    if ((&upper) || !(|upper)) begin
      sat_val = sample_in[DW-1:0];
    end else if (sample_in[W-1]) begin
      sat_val = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_comb begin
    accept      = sample_valid & ready_q;
    load_word   = hold_full_q ? hold_q : word_q;
    // A load and a write in the same cycle: the load takes the old contents, the write refills.
    hold_full_d = accept | (hold_full_q & ~frame_start);
    frame_word  = frame_start ? load_word : word_q;
    // Position p carries word[DW-p] for p in 1..DW; p = 0 and p > DW are padding zeros.
    sdata_d = 1'b0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (next_pos == PW'(DW - i)) begin
        sdata_d = frame_word[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      word_q      <= '0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      underrun_q  <= frame_start & ~hold_full_q;
      if (accept) begin
        hold_q <= sat_val;
      end
      if (frame_start) begin
        word_q <= load_word;
      end
      if (fall) begin
        sdata_q <= sdata_d;
      end
    end
  end

  assign sample_ready = ready_q;
  assign i2s_sdata    = sdata_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer (W=32, DW=24, SLOT=32, BCLK_DIV=2).
// A cycle-level reference derives every expected output from the number of clock edges since
// reset release using plain arithmetic, plus a one-entry buffer model of the handshake.
module tb_i2s_tx_serializer;
  import audio_pkg::*;

  localparam int W   = 32;
  localparam int DW  = 24;
  localparam int SL  = 32;
  localparam int DIV = 2;
  localparam int FB  = 2 * SL;
  localparam int BCP = 2 * DIV;   // system clocks per BCLK period

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic         i2s_bclk;
  logic         i2s_lrclk;
  logic         i2s_sdata;
  logic         underrun;

  i2s_tx_serializer #(
    .W        (W),
    .DW       (DW),
    .SLOT     (SL),
    .BCLK_DIV (DIV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;

  function automatic logic [DW-1:0] sat_ref(input logic [W-1:0] x);
    longint v;
    v = longint'($signed(x));
    if (v > longint'(SAT_MAX)) v = longint'(SAT_MAX);
    else if (v < longint'(SAT_MIN)) v = longint'(SAT_MIN);
    return v[DW-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic          in_valid_s = 1'b0;
  logic          in_reset_s = 1'b1;
  logic [W-1:0]  in_data_s = '0;
  int            k = 0;
  int            frame_cnt = 0;
  logic          m_full = 1'b0;
  logic [DW-1:0] m_hold = '0;
  logic [DW-1:0] m_last = '0;
  logic [DW-1:0] m_word = '0;
  logic          m_acc;
  logic          e_und;
  logic [4:0]    e_vec;
  logic [4:0]    g_vec;
  logic [DW-1:0] sh;
  int            mf;
  int            pp;

  always @(posedge clock) begin
    in_valid_s = sample_valid;
    in_data_s  = sample_in;
    in_reset_s = reset;
  end

  always @(negedge clock) begin
    e_und = 1'b0;
    if (in_reset_s) begin
      k = 0; m_full = 1'b0; m_hold = '0; m_last = '0; m_word = '0;
    end else begin
      k++;
      m_acc = in_valid_s && !m_full;
      if (k % BCP == 0) begin
        mf = k / BCP;
        if (mf == 1 || mf % FB == 0) begin
          e_und  = !m_full;
          m_word = m_full ? m_hold : m_last;
          m_last = m_word;
          m_full = 1'b0;
          frame_cnt++;
        end
      end
      if (m_acc) begin
        m_hold = sat_ref(in_data_s);
        m_full = 1'b1;
      end
    end
    mf = k / BCP;
    pp = mf % SL;
    sh = m_word >> (DW - pp);
    e_vec[4] = ((k / DIV) % 2) == 1;
    e_vec[3] = (mf % FB) >= SL;
    e_vec[2] = (mf > 0 && pp >= 1 && pp <= DW) ? sh[0] : 1'b0;
    e_vec[1] = e_und;
    e_vec[0] = !m_full;
    g_vec = {i2s_bclk, i2s_lrclk, i2s_sdata, underrun, sample_ready};
    vectors++;
    if (g_vec !== e_vec) begin
      miscompares++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL cycle k=%0d {bclk,lrclk,sdata,underrun,ready} got %b expected %b",
                 k, g_vec, e_vec);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_neg();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_frame();
    int f0;
    int n;
    f0 = frame_cnt;
    n = 0;
    while (frame_cnt == f0 && n < 1000) begin
      wait_neg();
      n++;
    end
    if (n >= 1000) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (n < 2000) begin
      @(negedge clock);
      if (sample_ready === 1'b1) break;
      n++;
    end
    if (n >= 2000) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    wait_neg();
    sample_valid = 1'b1;
    sample_in = d;
    wait_ready();
    wait_neg();
  endtask

  // Deserialise the next frame that starts with a bit-count wrap; also count underrun pulses.
  task automatic capture(output logic [DW-1:0] l, output logic [DW-1:0] r, output int und);
    logic prev;
    int   j;
    wait_frame();
    l = '0; r = '0;
    und = int'(underrun);
    prev = i2s_bclk;
    j = -1;
    for (int c = 0; c < FB * BCP; c++) begin
      wait_neg();
      und += int'(underrun);
      if (i2s_bclk && !prev) begin
        j++;
        if (j >= 1 && j <= DW) l = {l[DW-2:0], i2s_sdata};
        if (j >= SL + 1 && j <= SL + DW) r = {r[DW-2:0], i2s_sdata};
      end
      prev = i2s_bclk;
      if (j == FB - 1) break;
    end
  endtask

  // Present a sample so that valid is already high at the next frame-load edge.
  task automatic drive_on_load(input logic [W-1:0] d);
    int kl;
    kl = ((k / (BCP * FB)) + 1) * (BCP * FB);
    while (k < kl - 1) wait_neg();
    sample_valid = 1'b1;
    sample_in = d;
    wait_ready();
  endtask

  typedef struct {
    logic [W-1:0]  din;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t tbl[9];
  logic bclk_exp[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] la, ra, lb, rb;
    int            ua, ub;
    int            accs, fprev, intervals;
    logic [W-1:0]  d;

    tbl[0] = '{32'h0012_3456, 24'h123456};
    tbl[1] = '{32'h7FFF_FFFF, 24'h7FFFFF};
    tbl[2] = '{32'h8000_0000, 24'h800000};
    tbl[3] = '{32'h007F_FFFF, 24'h7FFFFF};
    tbl[4] = '{32'h0080_0000, 24'h7FFFFF};
    tbl[5] = '{32'hFF80_0000, 24'h800000};
    tbl[6] = '{32'hFF7F_FFFF, 24'h800000};
    tbl[7] = '{32'hFFFF_FFFF, 24'hFFFFFF};
    tbl[8] = '{32'hFFAB_CDEF, 24'hABCDEF};
    bclk_exp[0] = 1'b0; bclk_exp[1] = 1'b1; bclk_exp[2] = 1'b1; bclk_exp[3] = 1'b0;

    reset = 1'b1;
    repeat (3) wait_neg();
    reset = 1'b0;
    wait_frame();

    // Saturation / data table: each sample appears in both slots of the following frame.
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].din);
      capture(la, ra, ua);
      check($sformatf("tbl%0d_left", i), 32'(la), 32'(tbl[i].dout));
      check($sformatf("tbl%0d_right", i), 32'(ra), 32'(tbl[i].dout));
    end

    // Reset held 5 cycles mid-frame, with a sample pending in the holding register.
    repeat ($urandom_range(20, 100)) wait_neg();
    sample_valid = 1'b1;
    sample_in = 32'h0055_AA55;
    wait_neg();
    sample_valid = 1'b0;
    reset = 1'b1;
    repeat (5) wait_neg();
    check("rst_bclk", 32'(i2s_bclk), 32'd0);
    check("rst_lrclk", 32'(i2s_lrclk), 32'd0);
    check("rst_sdata", 32'(i2s_sdata), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_neg();
      check($sformatf("post_rst_bclk%0d", i + 1), 32'(i2s_bclk), 32'(bclk_exp[i]));
    end
    check("post_rst_underrun", 32'(underrun), 32'd1);

    // One sample, then nothing: the next frame repeats it with one underrun pulse.
    send(32'h0000_0001);
    capture(la, ra, ua);
    check("rep_first_left", 32'(la), 32'h1);
    capture(lb, rb, ub);
    check("rep_again_left", 32'(lb), 32'h1);
    check("rep_again_right", 32'(rb), 32'h1);
    check("rep_underrun_cycles", 32'(ub), 32'd1);

    // Write presented on the exact frame-load cycle while the holding register is full.
    wait_frame();
    send(32'h0013_5799);
    fork
      capture(la, ra, ua);
      drive_on_load(32'h0065_4321);
    join
    check("loadwr_old_left", 32'(la), 32'h135799);
    check("loadwr_old_underrun", 32'(ua), 32'd0);
    capture(lb, rb, ub);
    check("loadwr_new_left", 32'(lb), 32'h654321);
    check("loadwr_new_underrun", 32'(ub), 32'd0);

    // valid held high with changing data: exactly one transfer per frame.
    accs = 0;
    intervals = 0;
    fprev = frame_cnt;
    sample_valid = 1'b1;
    sample_in = $urandom;
    for (int c = 0; c < 4 * FB * BCP; c++) begin
      wait_neg();
      if (frame_cnt != fprev) begin
        if (intervals > 0) check("accepts_per_frame", 32'(accs), 32'd1);
        intervals++;
        accs = 0;
        fprev = frame_cnt;
      end
      if (sample_ready === 1'b1) accs++;
      sample_in = $urandom;
    end
    sample_valid = 1'b0;

    // Random traffic with random gaps; every cycle is checked by the reference model.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 300)) wait_neg();
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d = {{8{d[23]}}, d[23:0]};
      send(d);
    end

    repeat (600) wait_neg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
